// File: rtl/alu_arbiter.sv
// Purpose: round-robin sharing of one combinational ALU between two valid/ready requesters.
// Latency: request accepted in cycle T -> response valid from cycle T+2 (one EXEC cycle), 3-cycle minimum per op.
// Backpressure: one op in flight; both req readies stay low until the owner's response is taken.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  input  logic [SELW-1:0]  req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  input  logic [SELW-1:0]  req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_sal,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;      // requester served most recently
  logic             owner;     // requester that owns the in-flight op
  logic             grant;     // 0 -> requester 0, 1 -> requester 1
  logic             accept;    // handshake in IDLE
  logic             rsp_done;  // owner consumed the response
  logic [WIDTH-1:0] result;

  // Round-robin pick: a lone valid wins, a tie goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state and handshake outputs; readies are also forced low while reset is held.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = rst_n & req0_valid & ~grant;
        req1_ready = rst_n & req1_valid & grant;
        accept     = req0_ready | req1_ready;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp_done   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, result capture after the EXEC cycle, round-robin history on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_sel <= '0;
      result  <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else begin
      if (accept) begin
        alu_rs1 <= grant ? req1_rs1 : req0_rs1;
        alu_rs2 <= grant ? req1_rs2 : req0_rs2;
        alu_sel <= grant ? req1_sel : req0_sel;
        owner   <= grant;
      end
      if (state == EXEC) begin
        result <= alu_sal;
      end
      if (rsp_done) begin
        last <= owner;
      end
    end
  end

  // Result register feeds both response ports; rsp*_valid alone says whose it is.
  assign rsp0_data = result;
  assign rsp1_data = result;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stub ALU (sel 0 add, sel 1 sub, else xor).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int SELW  = 3;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0] req0_rs1, req0_rs2, rsp0_data;
  logic [SELW-1:0]  req0_sel;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] req1_rs1, req1_rs2, rsp1_data;
  logic [SELW-1:0]  req1_sel;
  logic [WIDTH-1:0] alu_rs1, alu_rs2, alu_sal;
  logic [SELW-1:0]  alu_sel;
  logic             busy;

  int n_checks;
  int n_pass;

  alu_arbiter #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rs1   (req0_rs1),
    .req0_rs2   (req0_rs2),
    .req0_sel   (req0_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rs1   (req1_rs1),
    .req1_rs2   (req1_rs2),
    .req1_sel   (req1_sel),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_sel    (alu_sel),
    .alu_sal    (alu_sal),
    .busy       (busy)
  );

  // Stub ALU.
  always_comb begin
    if (alu_sel == 3'd0)      alu_sal = alu_rs1 + alu_rs2;
    else if (alu_sel == 3'd1) alu_sal = alu_rs1 - alu_rs2;
    else                      alu_sal = alu_rs1 ^ alu_rs2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   busy,       0);
    check({tag, "_rdy0"},   req0_ready, 0);
    check({tag, "_rdy1"},   req1_ready, 0);
    check({tag, "_rspv0"},  rsp0_valid, 0);
    check({tag, "_rspv1"},  rsp1_valid, 0);
    check({tag, "_alurs1"}, alu_rs1,    0);
    check({tag, "_alurs2"}, alu_rs2,    0);
    check({tag, "_alusel"}, alu_sel,    0);
    check({tag, "_rspd1"},  rsp1_data,  0);
  endtask

  logic              g0;
  logic [WIDTH-1:0]  exp_d;
  logic [WIDTH-1:0]  v_rs1 [3];
  logic [WIDTH-1:0]  v_rs2 [3];
  logic [SELW-1:0]   v_sel [3];
  logic [WIDTH-1:0]  v_res [3];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req0_valid = 0; req0_rs1 = 0; req0_rs2 = 0; req0_sel = 0; rsp0_ready = 0;
    req1_valid = 0; req1_rs1 = 0; req1_rs2 = 0; req1_sel = 0; rsp1_ready = 0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_rspd0", rsp0_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single req0 add: 226 + 7.
    req0_valid = 1; req0_rs1 = 226; req0_rs2 = 7; req0_sel = 0; rsp0_ready = 1;
    @(negedge clk);
    check("t2_rdy0", req0_ready, 1);
    check("t2_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("t2_exec_busy", busy, 1);
    check("t2_exec_rspv", rsp0_valid, 0);
    check("t2_alu_rs1", alu_rs1, 226);
    check("t2_alu_rs2", alu_rs2, 7);
    tick();
    @(negedge clk);
    check("t2_rspv0", rsp0_valid, 1);
    check("t2_rspd0", rsp0_data, 233);
    check("t2_rspv1", rsp1_valid, 0);
    tick();
    @(negedge clk);
    check("t2_done_busy", busy, 0);
    check("t2_done_rspv0", rsp0_valid, 0);

    // Fresh reset so the tie history starts over.
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // Both requesters valid continuously: grants must go 0,1,0,1.
    req0_valid = 1; req0_rs1 = 1;   req0_rs2 = 2;  req0_sel = 0;
    req1_valid = 1; req1_rs1 = 100; req1_rs2 = 20; req1_sel = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      g0    = (i % 2 == 0);
      exp_d = g0 ? 32'd3 : 32'd120;
      @(negedge clk);
      check("t3_rdy0", req0_ready, g0);
      check("t3_rdy1", req1_ready, !g0);
      tick(); tick();
      @(negedge clk);
      check("t3_rspv0", rsp0_valid, g0);
      check("t3_rspv1", rsp1_valid, !g0);
      check("t3_rspd", g0 ? rsp0_data : rsp1_data, exp_d);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // req1 sub 50 - 8 with its response held off for 5 cycles while req0 waits.
    req1_valid = 1; req1_rs1 = 50; req1_rs2 = 8; req1_sel = 1; rsp1_ready = 0;
    @(negedge clk);
    check("t4_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_rs1 = 1; req0_rs2 = 1; req0_sel = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_rspv1", rsp1_valid, 1);
      check("t4_hold_rspd1", rsp1_data, 42);
      check("t4_hold_rdy0", req0_ready, 0);
      check("t4_hold_busy", busy, 1);
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk);
    check("t4_take_rspv1", rsp1_valid, 1);
    check("t4_take_rdy0", req0_ready, 0);
    tick();
    @(negedge clk);
    check("t4_after_rspv1", rsp1_valid, 0);
    check("t4_after_rdy0", req0_ready, 1);
    req0_valid = 0;
    tick();

    // Reset asserted mid-EXEC: outputs clear at once and the op is dropped.
    req1_valid = 1; req1_rs1 = 77; req1_rs2 = 3; req1_sel = 0;
    @(negedge clk);
    check("t5_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_idle_outputs("t5_rst");
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_rspv1", rsp1_valid, 0);
      check("t5_no_busy", busy, 0);
      tick();
    end
    req1_valid = 1; req1_rs1 = 10; req1_rs2 = 5; req1_sel = 0;
    @(negedge clk);
    check("t5_new_rdy1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    @(negedge clk);
    check("t5_new_rspv1", rsp1_valid, 1);
    check("t5_new_rspd1", rsp1_data, 15);
    tick();

    // Back-to-back req0 with rsp0_ready high: one accept every 3 cycles.
    v_rs1[0] = 5;  v_rs2[0] = 3;  v_sel[0] = 0; v_res[0] = 8;
    v_rs1[1] = 9;  v_rs2[1] = 4;  v_sel[1] = 1; v_res[1] = 5;
    v_rs1[2] = 12; v_rs2[2] = 10; v_sel[2] = 2; v_res[2] = 6;
    rsp0_ready = 1;
    req0_valid = 1;
    req0_rs1 = v_rs1[0]; req0_rs2 = v_rs2[0]; req0_sel = v_sel[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_rdy0", req0_ready, 1);
      tick();
      if (i < 2) begin
        req0_rs1 = v_rs1[i+1]; req0_rs2 = v_rs2[i+1]; req0_sel = v_sel[i+1];
      end else begin
        req0_valid = 0;
      end
      @(negedge clk);
      check("t6_exec_rdy0", req0_ready, 0);
      check("t6_alu_sel", alu_sel, v_sel[i]);
      tick();
      @(negedge clk);
      check("t6_rspv0", rsp0_valid, 1);
      check("t6_rspd0", rsp0_data, v_res[i]);
      tick();
    end
    @(negedge clk);
    check("t6_end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
